// File: rtl/counter_pkg.sv
// Shared types and defaults for the bounded up/down counter family.
package counter_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count, boundary-event and load-clamp computation.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  cnt_mode_e         mode,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              inc,
  input  logic              dec,
  output logic [WIDTH-1:0]  next_c,
  output logic              ovf_c,
  output logic              unf_c,
  output logic              halt_c,
  output logic [WIDTH-1:0]  load_clamped_c
);

  localparam int unsigned EW = WIDTH + 1;

  // One extra bit so sums past max_val are visible instead of wrapping.
  logic [EW-1:0] cnt_x, step_x, min_x, max_x, sum_x, lo_x;
  logic [WIDTH-1:0] load_hi;

  assign cnt_x = EW'(count);
  assign step_x = EW'(step);
  assign min_x = EW'(min_val);
  assign max_x = EW'(max_val);
  assign sum_x = cnt_x + step_x;
  assign lo_x  = min_x + step_x;

  assign ovf_c = inc & (sum_x > max_x);
  assign unf_c = dec & (cnt_x < lo_x);

  always_comb begin
    next_c = count;
    halt_c = 1'b0;
    if (ovf_c) begin
      case (mode)
        CNT_SAT:     next_c = max_val;
        CNT_ONESHOT: begin
          next_c = max_val;
          halt_c = 1'b1;
        end
        default:     next_c = min_val;
      endcase
    end else if (unf_c) begin
      case (mode)
        CNT_SAT:     next_c = min_val;
        CNT_ONESHOT: begin
          next_c = min_val;
          halt_c = 1'b1;
        end
        default:     next_c = max_val;
      endcase
    end else if (inc) begin
      next_c = WIDTH'(sum_x);
    end else if (dec) begin
      next_c = WIDTH'(cnt_x - step_x);
    end
  end

  // Upper clamp first so an inverted range still resolves deterministically.
  assign load_hi        = (load_value > max_val) ? max_val : load_value;
  assign load_clamped_c = (load_hi < min_val) ? min_val : load_hi;

endmodule

// File: rtl/updown_bounded_counter.sv
// Bounded up/down counter with wrap/saturate/one-shot modes and sticky flags.
module updown_bounded_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [1:0]        mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              tc_pulse,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  output logic              halted,
  output logic              cfg_err
);

  run_state_e       state, state_d;
  logic [WIDTH-1:0] count_d, calc_next, load_clamped;
  logic             tc_d, ovf_d, unf_d;
  logic             can_count, inc, dec, ovf_ev, unf_ev, halt_ev;

  assign cfg_err = (min_val > max_val);
  assign at_max  = (count == max_val);
  assign at_min  = (count == min_val);
  assign halted  = (state == ST_HALT);

  assign can_count = (state == ST_RUN) & ~cfg_err & (step != '0);
  assign inc       = en & up & ~down & can_count;
  assign dec       = en & down & ~up & can_count;

  counter_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_calc (
    .count          (count),
    .step           (step),
    .min_val        (min_val),
    .max_val        (max_val),
    .mode           (cnt_mode_e'(mode)),
    .load_value     (load_value),
    .inc            (inc),
    .dec            (dec),
    .next_c         (calc_next),
    .ovf_c          (ovf_ev),
    .unf_c          (unf_ev),
    .halt_c         (halt_ev),
    .load_clamped_c (load_clamped)
  );

  // Next-state: load beats counting; a flag set beats a same-cycle clear.
  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    ovf_d   = ovf_sticky & ~clr_flags;
    unf_d   = unf_sticky & ~clr_flags;
    state_d = state;
    if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
    end else if (inc | dec) begin
      count_d = calc_next;
      tc_d    = ovf_ev | unf_ev;
      ovf_d   = ovf_d | ovf_ev;
      unf_d   = unf_d | unf_ev;
      if (halt_ev) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= min_val;
      tc_pulse   <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      state      <= ST_RUN;
    end else begin
      count      <= count_d;
      tc_pulse   <= tc_d;
      ovf_sticky <= ovf_d;
      unf_sticky <= unf_d;
      state      <= state_d;
    end
  end

endmodule

// File: tb/tb_updown_bounded_counter.sv
// Scoreboard bench: driver queues hand-computed results, monitor checks each cycle.
module tb_updown_bounded_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, down, load, clr_flags;
  logic [7:0] load_value, min_val, max_val, count;
  logic [3:0] step;
  logic [1:0] mode;
  logic       at_max, at_min, tc_pulse, ovf_sticky, unf_sticky, halted, cfg_err;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  count;
    logic        tc, ovf, unf, hlt, amax, amin, cerr;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  updown_bounded_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up         (up),
    .down       (down),
    .load       (load),
    .load_value (load_value),
    .step       (step),
    .min_val    (min_val),
    .max_val    (max_val),
    .mode       (mode),
    .clr_flags  (clr_flags),
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .tc_pulse   (tc_pulse),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky),
    .halted     (halted),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop every entry due this cycle, shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    cyc_cnt++;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      if (e.cyc < cyc_cnt) begin
        chk("missed_entry", e.cyc, int'(cyc_cnt), int'(e.cyc));
      end else begin
        chk("count",      e.cyc, int'(count),      int'(e.count));
        chk("tc_pulse",   e.cyc, int'(tc_pulse),   int'(e.tc));
        chk("ovf_sticky", e.cyc, int'(ovf_sticky), int'(e.ovf));
        chk("unf_sticky", e.cyc, int'(unf_sticky), int'(e.unf));
        chk("halted",     e.cyc, int'(halted),     int'(e.hlt));
        chk("at_max",     e.cyc, int'(at_max),     int'(e.amax));
        chk("at_min",     e.cyc, int'(at_min),     int'(e.amin));
        chk("cfg_err",    e.cyc, int'(cfg_err),    int'(e.cerr));
      end
    end
  end

  // Queue the state expected after the next edge, then advance to the next negedge.
  task automatic tick(input int c, input bit tc, input bit ovf, input bit unf, input bit hlt);
    exp_t e;
    e.cyc   = cyc_cnt + 1;
    e.count = 8'(c);
    e.tc    = tc;
    e.ovf   = ovf;
    e.unf   = unf;
    e.hlt   = hlt;
    e.amax  = (8'(c) == max_val);
    e.amin  = (8'(c) == min_val);
    e.cerr  = (min_val > max_val);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; clr_flags = 1'b0;
    load_value = 8'd0; step = 4'd3; min_val = 8'd10; max_val = 8'd20; mode = 2'b00;
    @(negedge clk);

    // Reset and wrap overflow
    tick(10, 0, 0, 0, 0);
    rst_n = 1'b1; load = 1'b1; load_value = 8'd19;
    tick(19, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(10, 1, 1, 0, 0);
    en = 1'b0; up = 1'b0;
    tick(10, 0, 1, 0, 0);

    // Saturating underflow, repeated at the bound
    mode = 2'b01; load = 1'b1; load_value = 8'd11;
    tick(11, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1; down = 1'b1;
    tick(10, 1, 1, 1, 0);
    tick(10, 1, 1, 1, 0);
    load = 1'b1; load_value = 8'd16;
    tick(16, 0, 1, 1, 0);
    load = 1'b0;
    tick(13, 0, 1, 1, 0);
    en = 1'b0; down = 1'b0; clr_flags = 1'b1;
    tick(13, 0, 0, 0, 0);

    // up=down hold, step=0 hold, plain increment
    clr_flags = 1'b0; min_val = 8'd0; load = 1'b1; load_value = 8'd7;
    tick(7, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1; down = 1'b1;
    tick(7, 0, 0, 0, 0);
    down = 1'b0; step = 4'd0;
    tick(7, 0, 0, 0, 0);
    step = 4'd3;
    tick(10, 0, 0, 0, 0);

    // Set wins over simultaneous clear
    mode = 2'b00; min_val = 8'd10; en = 1'b0; load = 1'b1; load_value = 8'd19;
    tick(19, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1; clr_flags = 1'b1;
    tick(10, 1, 1, 0, 0);
    en = 1'b0;
    tick(10, 0, 0, 0, 0);

    // One-shot halt and release by load
    clr_flags = 1'b0; mode = 2'b10; min_val = 8'd0; max_val = 8'd5; step = 4'd2;
    load = 1'b1; load_value = 8'd0;
    tick(0, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(2, 0, 0, 0, 0);
    tick(4, 0, 0, 0, 0);
    tick(5, 1, 1, 0, 1);
    tick(5, 0, 1, 0, 1);
    load = 1'b1; load_value = 8'd3;
    tick(3, 0, 1, 0, 0);

    // Load clamp, reset mid-count, inverted bounds
    mode = 2'b00; min_val = 8'd10; max_val = 8'd20; step = 4'd3; load_value = 8'd250;
    tick(20, 0, 1, 0, 0);
    load = 1'b0; rst_n = 1'b0;
    tick(10, 0, 0, 0, 0);
    rst_n = 1'b1; min_val = 8'd30;
    tick(10, 0, 0, 0, 0);

    // Degenerate range min == max
    min_val = 8'd10; max_val = 8'd10; mode = 2'b01; step = 4'd1;
    tick(10, 1, 1, 0, 0);
    mode = 2'b00; up = 1'b0; down = 1'b1;
    tick(10, 1, 1, 1, 0);
    en = 1'b0; down = 1'b0;

    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("queue_drain", cyc_cnt, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
